glb_bank_array: RTL
===================

GLB_BANK_ARRAY -- requirements
Module: glb_bank_array

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, element width; bank entry width is 2*DATA_WIDTH.
REQ-002 SHALL have parameter DEPTH, default 512, entries per bank; power of two; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter TAG_W, default 4, x_tag width.
REQ-004 SHALL have port bus_clk, input, 1, clock.
REQ-005 SHALL have port rstn, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, IDLE->ACTIVE request.
REQ-007 SHALL have port flush, input, 1, clear all banks.
REQ-008 SHALL have port wr_valid, input, 1, write request.
REQ-009 SHALL have port wr_type, input, 2, target type: 0=none, 1=ifmap, 2=fltr, 3=psum.
REQ-010 SHALL have port wr_data, input, 2*DATA_WIDTH, write data; ifmap/fltr use the low DATA_WIDTH bits.
REQ-011 SHALL have port wr_ready, output, 1, write accepted this cycle when high with wr_valid.
REQ-012 SHALL have port rd_req, input, 3, per-bank read request; bit0 = ifmap, bit1 = fltr, bit2 = psum.
REQ-013 SHALL have port rd_valid, output, 3, per-bank read data valid.
REQ-014 SHALL have port rd_data, output, 6*DATA_WIDTH, bank b occupies [b*2*DATA_WIDTH +: 2*DATA_WIDTH].
REQ-015 SHALL have port kernel_len, input, AW+1, filter reuse length.
REQ-016 SHALL have port count, output, 3*(AW+1), per-bank occupancy, bank b at [b*(AW+1) +: AW+1].
REQ-017 SHALL have ports full and empty, output, 3 each, per-bank status.
REQ-018 SHALL have port x_tag, output, TAG_W, filter column tag.
REQ-019 SHALL have port busy, output, 1, high when state != IDLE.

Function
REQ-020 SHALL implement FSM IDLE/ACTIVE/FLUSH: IDLE->ACTIVE on start; ACTIVE->FLUSH on flush; FLUSH->IDLE unconditionally after 1 cycle; flush in IDLE -> FLUSH; flush has priority over start.
REQ-021 SHALL clear all pointers and counts in FLUSH; wr_ready = 0 and reads ignored in FLUSH.
REQ-022 SHALL accept writes in IDLE and ACTIVE; wr_ready = !full[target] for types 1-3, and 1 for type 0 (write dropped).
REQ-023 SHALL write an accepted word at the bank write pointer, increment it modulo DEPTH, and increment count.
REQ-024 SHALL honour rd_req only in ACTIVE and only when the bank has data; all other requests are ignored with rd_valid = 0.
REQ-025 SHALL present read data with 1-cycle latency: request in cycle N gives rd_valid and rd_data in cycle N+1; rd_data holds its value otherwise.
REQ-026 SHALL treat ifmap and psum as destructive FIFOs: each read increments rd_ptr modulo DEPTH and decrements count.
REQ-027 SHALL treat fltr as non-destructive: a read is honoured only if 0 < kernel_len <= count[1]; rd_ptr advances 0..kernel_len-1 then wraps to 0; count is unchanged.
REQ-028 SHALL handle a simultaneous accepted write and honoured read on the same bank: both take effect and count is unchanged; a write while full is not accepted, even with a read in the same cycle.
REQ-029 SHALL drive full[b] = (count == DEPTH) and empty[b] = (count == 0).
REQ-030 SHALL zero-extend ifmap/fltr rd_data in the upper DATA_WIDTH bits.

Reset
REQ-031 SHALL, on rstn low, asynchronously set state IDLE and zero all pointers, counts, rd_valid, rd_data and x_tag; this gives empty = 3'b111, full = 0 and busy = 0.
REQ-032 SHALL abandon any in-flight read on reset mid-operation; rd_valid is 0 in the first cycle after release; memory contents are not cleared.

Configuration
REQ-033 SHALL, with GLB_XTAG_EN defined, increment x_tag on each honoured fltr read, wrap it to 0 after kernel_len-1, and clear it in FLUSH and on reset.
REQ-034 SHALL, without GLB_XTAG_EN, tie x_tag to 0 and include no x_tag logic.

Verification (DEPTH=8, DATA_WIDTH=16)
REQ-035 SHALL cover: write ifmap 0x11..0x18, start, rd_req[0] x8 -> data 0x11..0x18 at 1-cycle latency; full[0] 1 before reads, empty[0] 1 after.
REQ-036 SHALL cover: 9th ifmap write when full -> wr_ready = 0, count[0] stays 8; 9th read -> rd_valid[0] = 0.
REQ-037 SHALL cover: fltr load A,B,C, kernel_len = 3, 7 reads -> A,B,C,A,B,C,A; count[1] stays 3; x_tag 0,1,2,0,1,2,0 (macro on), constant 0 (macro off).
REQ-038 SHALL cover: psum with count 4 gets simultaneous write and read -> count stays 4; a write with wr_type = 0 -> wr_ready = 1 and no count change.
REQ-039 SHALL cover: flush in ACTIVE with all banks non-empty -> busy high 1 cycle in FLUSH, wr_ready = 0, then IDLE with all counts 0.
REQ-040 SHALL cover: rstn asserted the cycle after a rd_req -> rd_valid = 0, counts 0, state IDLE.

Source files
------------

// File: rtl/glb_bank_array.sv
// ============================================================================
// glb_bank_array : three-bank global buffer (ifmap FIFO, filter reuse, psum FIFO)
// Optional x_tag filter-column counter built only when GLB_XTAG_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module glb_bank_array #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 512,
  parameter int TAG_W      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                      bus_clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      flush,
  input  logic                      wr_valid,
  input  logic [1:0]                wr_type,
  input  logic [2*DATA_WIDTH-1:0]   wr_data,
  output logic                      wr_ready,
  input  logic [2:0]                rd_req,
  output logic [2:0]                rd_valid,
  output logic [6*DATA_WIDTH-1:0]   rd_data,
  input  logic [AW:0]               kernel_len,
  output logic [3*(AW+1)-1:0]       count,
  output logic [2:0]                full,
  output logic [2:0]                empty,
  output logic [TAG_W-1:0]          x_tag,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] w_full;
  logic [2:0] w_rd_en;
  logic       w_wr_ready;
  logic       w_wr_acc;

  always_ff @(posedge bus_clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (flush) w_state_nxt = FLUSH;
               else if (start) w_state_nxt = ACTIVE;
      ACTIVE:  if (flush) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Type 0 is always "accepted" so a null write never stalls the source.
  always_comb begin
    w_wr_ready = 1'b0;
    if (r_state != FLUSH) begin
      case (wr_type)
        2'd0:    w_wr_ready = 1'b1;
        2'd1:    w_wr_ready = !w_full[0];
        2'd2:    w_wr_ready = !w_full[1];
        default: w_wr_ready = !w_full[2];
      endcase
    end
  end

  assign wr_ready = w_wr_ready;
  assign w_wr_acc = wr_valid && w_wr_ready && (wr_type != 2'd0);
  assign busy     = (r_state != IDLE);
  assign full     = w_full;

  for (genvar g = 0; g < 3; g++) begin : g_bank
    localparam int BW = (g == 2) ? 2*DATA_WIDTH : DATA_WIDTH;

    logic [BW-1:0]           r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_count;
    logic [2*DATA_WIDTH-1:0] r_rd_data;
    logic                    r_rd_valid;
    logic                    w_wr_en;
    logic                    w_rd_ok;
    logic                    w_pop;

    assign w_wr_en = w_wr_acc && (wr_type == 2'(g + 1));

    if (g == 1) begin : g_fltr_gate
      assign w_rd_ok = (kernel_len != '0) && (kernel_len <= r_count);
      assign w_pop   = 1'b0;
    end else begin : g_fifo_gate
      assign w_rd_ok = 1'b1;
      assign w_pop   = w_rd_en[g];
    end

    assign w_rd_en[g] = (r_state == ACTIVE) && rd_req[g] && (r_count != '0) && w_rd_ok;

    always_ff @(posedge bus_clk or negedge rstn) begin
      if (!rstn) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else if (r_state == FLUSH) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
        // The filter bank replays its first kernel_len entries instead of draining.
        if (w_rd_en[g]) begin
          if ((g == 1) && ({1'b0, r_rd_ptr} == kernel_len - 1'b1)) r_rd_ptr <= '0;
          else                                                     r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_wr_en && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_wr_en && w_pop) r_count <= r_count - 1'b1;
      end
    end

    always_ff @(posedge bus_clk or negedge rstn) begin
      if (!rstn) begin
        r_rd_valid <= 1'b0;
        r_rd_data  <= '0;
      end else begin
        r_rd_valid <= w_rd_en[g];
        if (w_rd_en[g]) r_rd_data <= (2*DATA_WIDTH)'(r_mem[r_rd_ptr]);
      end
    end

    always_ff @(posedge bus_clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= wr_data[BW-1:0];
    end

    assign count[g*(AW+1) +: AW+1]                 = r_count;
    assign w_full[g]                               = (r_count == (AW+1)'(DEPTH));
    assign empty[g]                                = (r_count == '0);
    assign rd_valid[g]                             = r_rd_valid;
    assign rd_data[g*2*DATA_WIDTH +: 2*DATA_WIDTH] = r_rd_data;
  end

`ifdef GLB_XTAG_EN
  logic [TAG_W-1:0] r_x_tag;

  always_ff @(posedge bus_clk or negedge rstn) begin
    if (!rstn)                  r_x_tag <= '0;
    else if (r_state == FLUSH)  r_x_tag <= '0;
    else if (w_rd_en[1]) begin
      if (32'(r_x_tag) == 32'(kernel_len) - 32'd1) r_x_tag <= '0;
      else                                         r_x_tag <= r_x_tag + 1'b1;
    end
  end

  assign x_tag = r_x_tag;
`else
  assign x_tag = '0;
`endif

endmodule

`default_nettype wire
